// File: rtl/master_uart_link.sv
// master_uart_link: full-duplex framed serial link, W-bit words LSB first with a frame-valid line.
// TX and RX run as independent FSMs; RX inputs are asynchronous and pass 2-flop synchronizers.
module master_uart_link #(
  parameter int W            = 16,
  parameter int CLKS_PER_BIT = 100,
  parameter int GAP_BITS     = 1
) (
  input  logic         clk_i,
  input  logic         clr_ni,
  input  logic         send_i,
  input  logic [W-1:0] tx_data_i,
  output logic         tx_busy_o,
  output logic         tx_bit_o,
  output logic         tx_sig_o,
  input  logic         rx_bit_i,
  input  logic         rx_sig_i,
  output logic [W-1:0] rx_data_o,
  output logic         rx_valid_o,
  output logic         rx_err_o
);
  localparam int CW = $clog2(GAP_BITS*CLKS_PER_BIT+1);
  localparam int BW = $clog2(W);
  localparam logic [CW-1:0] BIT_END  = CW'(CLKS_PER_BIT-1);
  localparam logic [CW-1:0] HALF_END = CW'(CLKS_PER_BIT/2-1);
  localparam logic [CW-1:0] GAP_END  = CW'(GAP_BITS*CLKS_PER_BIT-1);
  localparam logic [BW-1:0] LAST     = BW'(W-1);

  typedef enum logic [1:0] {T_IDLE, T_DATA, T_GAP} tx_st_e;
  typedef enum logic [1:0] {R_IDLE, R_HALF, R_SAMPLE, R_WAITLOW} rx_st_e;

  tx_st_e tx_st_q, tx_st_d;
  logic [CW-1:0] tx_cnt_q, tx_cnt_d;
  logic [BW-1:0] tx_idx_q, tx_idx_d;
  logic [W-1:0] tx_sh_q, tx_sh_d;
  logic send_q;

  rx_st_e rx_st_q, rx_st_d;
  logic [CW-1:0] rx_cnt_q, rx_cnt_d;
  logic [BW-1:0] rx_idx_q, rx_idx_d;
  logic [W-1:0] rx_sh_q, rx_sh_d, rx_data_q, rx_data_d;
  logic rx_valid_q, rx_valid_d, rx_err_q, rx_err_d;
  logic [1:0] sig_sync_q, bit_sync_q;
  logic sig_prev_q;

  wire sig_s = sig_sync_q[1];
  wire bit_s = bit_sync_q[1];

  always_ff @(posedge clk_i or negedge clr_ni) begin
    if (!clr_ni) begin
      tx_st_q    <= T_IDLE;
      tx_cnt_q   <= '0;
      tx_idx_q   <= '0;
      tx_sh_q    <= '0;
      send_q     <= 1'b0;
      rx_st_q    <= R_IDLE;
      rx_cnt_q   <= '0;
      rx_idx_q   <= '0;
      rx_sh_q    <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      rx_err_q   <= 1'b0;
      sig_sync_q <= '0;
      bit_sync_q <= '0;
      sig_prev_q <= 1'b0;
    end else begin
      tx_st_q    <= tx_st_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_idx_q   <= tx_idx_d;
      tx_sh_q    <= tx_sh_d;
      send_q     <= send_i;
      rx_st_q    <= rx_st_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_idx_q   <= rx_idx_d;
      rx_sh_q    <= rx_sh_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      rx_err_q   <= rx_err_d;
      sig_sync_q <= {sig_sync_q[0], rx_sig_i};
      bit_sync_q <= {bit_sync_q[0], rx_bit_i};
      sig_prev_q <= sig_s;
    end
  end

  // Edges arriving while busy are dropped because send_q keeps tracking send_i.
  always_comb begin
    tx_st_d  = tx_st_q;
    tx_cnt_d = tx_cnt_q;
    tx_idx_d = tx_idx_q;
    tx_sh_d  = tx_sh_q;
    if (tx_st_q == T_IDLE) begin
      if (send_i && !send_q) begin
        tx_st_d  = T_DATA;
        tx_sh_d  = tx_data_i;
        tx_cnt_d = '0;
        tx_idx_d = '0;
      end
    end else if (tx_st_q == T_DATA) begin
      tx_cnt_d = tx_cnt_q + 1'b1;
      if (tx_cnt_q == BIT_END) begin
        tx_cnt_d = '0;
        tx_sh_d  = tx_sh_q >> 1;
        tx_idx_d = tx_idx_q + 1'b1;
        tx_st_d  = (tx_idx_q == LAST) ? T_GAP : T_DATA;
      end
    end else begin
      tx_cnt_d = tx_cnt_q + 1'b1;
      if (tx_cnt_q == GAP_END) begin
        tx_cnt_d = '0;
        tx_st_d  = T_IDLE;
      end
    end
  end

  always_comb begin
    tx_busy_o = tx_st_q != T_IDLE;
    tx_sig_o  = tx_st_q == T_DATA;
    tx_bit_o  = (tx_st_q == T_DATA) && tx_sh_q[0];
  end

  // First sample lands mid-bit after half a period; later ones a full period apart.
  always_comb begin
    rx_st_d    = rx_st_q;
    rx_cnt_d   = rx_cnt_q;
    rx_idx_d   = rx_idx_q;
    rx_sh_d    = rx_sh_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    rx_err_d   = 1'b0;
    if (rx_st_q == R_IDLE) begin
      if (sig_s && !sig_prev_q) begin
        rx_st_d  = R_HALF;
        rx_cnt_d = '0;
        rx_idx_d = '0;
      end
    end else if (rx_st_q == R_WAITLOW) begin
      rx_st_d = sig_s ? R_WAITLOW : R_IDLE;
    end else if (!sig_s) begin
      rx_err_d = 1'b1;
      rx_st_d  = R_IDLE;
    end else begin
      rx_cnt_d = rx_cnt_q + 1'b1;
      if (rx_cnt_q == ((rx_st_q == R_HALF) ? HALF_END : BIT_END)) begin
        rx_cnt_d = '0;
        rx_st_d  = R_SAMPLE;
        rx_sh_d  = {bit_s, rx_sh_q[W-1:1]};
        rx_idx_d = rx_idx_q + 1'b1;
        if (rx_idx_q == LAST) begin
          rx_data_d  = {bit_s, rx_sh_q[W-1:1]};
          rx_valid_d = 1'b1;
          rx_st_d    = R_WAITLOW;
        end
      end
    end
  end

  assign rx_data_o  = rx_data_q;
  assign rx_valid_o = rx_valid_q;
  assign rx_err_o   = rx_err_q;
endmodule

// File: tb/tb_master_uart_link.sv
// tb_master_uart_link: loopback and directly driven frames on a fast-baud instance,
// plus a default-parameter instance exercised full duplex.
module tb_master_uart_link;
  logic clk = 1'b0, clr_n, send, loop, drv_bit, drv_sig;
  logic [15:0] tx_data;
  logic tx_busy, tx_bit, tx_sig, rx_valid, rx_err, rx_bit, rx_sig;
  logic [15:0] rx_data;
  logic send2, drv2_bit, drv2_sig;
  logic [15:0] tx_data2, rx_data2;
  logic tx_busy2, tx_bit2, tx_sig2, rx_valid2, rx_err2;

  always #5 clk = ~clk;

  assign rx_bit = loop ? tx_bit : drv_bit;
  assign rx_sig = loop ? tx_sig : drv_sig;

  master_uart_link #(.W(16), .CLKS_PER_BIT(4), .GAP_BITS(1)) u_dut (
    .clk_i(clk), .clr_ni(clr_n), .send_i(send), .tx_data_i(tx_data),
    .tx_busy_o(tx_busy), .tx_bit_o(tx_bit), .tx_sig_o(tx_sig),
    .rx_bit_i(rx_bit), .rx_sig_i(rx_sig), .rx_data_o(rx_data),
    .rx_valid_o(rx_valid), .rx_err_o(rx_err));

  master_uart_link u_def (
    .clk_i(clk), .clr_ni(clr_n), .send_i(send2), .tx_data_i(tx_data2),
    .tx_busy_o(tx_busy2), .tx_bit_o(tx_bit2), .tx_sig_o(tx_sig2),
    .rx_bit_i(drv2_bit), .rx_sig_i(drv2_sig), .rx_data_o(rx_data2),
    .rx_valid_o(rx_valid2), .rx_err_o(rx_err2));

  typedef struct {
    logic [15:0] tx;
    logic [15:0] exp;
    int sig;
    int busy;
  } vec_t;

  vec_t tbl[4];
  logic [15:0] exp_q[$];
  int n_pass = 0, n_tot = 0;
  int sig_n = 0, busy_n = 0, valid_n = 0, err_n = 0, both_n = 0;
  int sig2_n = 0, busy2_n = 0, valid2_n = 0, err2_n = 0;
  int s_sig, s_busy, s_valid, s_err;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Advances n clocks, sampling 1ns after each edge; received words are scored here.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      if (tx_sig) sig_n++;
      if (tx_busy) busy_n++;
      if (rx_err) err_n++;
      if (rx_valid && rx_err) both_n++;
      if (rx_valid) begin
        valid_n++;
        chk("rx_pending", 32'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) chk("rx_word", 32'(rx_data), 32'(exp_q.pop_front()));
      end
      if (tx_sig2) sig2_n++;
      if (tx_busy2) busy2_n++;
      if (rx_valid2) valid2_n++;
      if (rx_err2) err2_n++;
    end
  endtask

  task automatic snap();
    s_sig = sig_n; s_busy = busy_n; s_valid = valid_n; s_err = err_n;
  endtask

  task automatic drive_frame(input logic [15:0] w, input int nbits, input int extra);
    drv_sig = 1'b1;
    for (int i = 0; i < nbits; i++) begin
      drv_bit = w[i];
      tick(4);
    end
    tick(extra);
    drv_sig = 1'b0;
    drv_bit = 1'b0;
  endtask

  initial begin
    logic [15:0] w_tx2, w_rx2;
    tbl[0] = '{16'h0000, 16'h0000, 64, 68};
    tbl[1] = '{16'hFFFF, 16'hFFFF, 64, 68};
    tbl[2] = '{16'h8001, 16'h8001, 64, 68};
    tbl[3] = '{16'hA5C3, 16'hA5C3, 64, 68};
    clr_n = 1'b0; send = 1'b0; loop = 1'b1; drv_bit = 1'b0; drv_sig = 1'b0; tx_data = '0;
    send2 = 1'b0; drv2_bit = 1'b0; drv2_sig = 1'b0; tx_data2 = '0;
    tick(3);
    chk("rst_tx_sig", 32'(tx_sig), 0);
    chk("rst_tx_busy", 32'(tx_busy), 0);
    chk("rst_rx_data", 32'(rx_data), 0);
    clr_n = 1'b1;
    tick(2);

    // held-high send yields one frame; data changes after latch are ignored
    snap();
    tx_data = 16'h0001; send = 1'b1; exp_q.push_back(16'h0001);
    tick(5);
    tx_data = 16'hBEEF;
    tick(295);
    send = 1'b0;
    tick(10);
    chk("hold_sig_cycles", 32'(sig_n - s_sig), 64);
    chk("hold_busy_cycles", 32'(busy_n - s_busy), 68);
    chk("hold_valid_cnt", 32'(valid_n - s_valid), 1);
    chk("hold_rx_data", 32'(rx_data), 32'h0001);

    // edge while busy is dropped, edge after busy starts a new frame
    snap();
    tx_data = 16'h00F0; send = 1'b1; exp_q.push_back(16'h00F0);
    tick(1); send = 1'b0; tick(20);
    tx_data = 16'h0F0F; send = 1'b1; tick(1); send = 1'b0; tick(75);
    chk("busy_edge_sig", 32'(sig_n - s_sig), 64);
    chk("busy_edge_valid", 32'(valid_n - s_valid), 1);
    chk("busy_edge_rx", 32'(rx_data), 32'h00F0);
    snap();
    send = 1'b1; exp_q.push_back(16'h0F0F);
    tick(1); send = 1'b0; tick(80);
    chk("second_sig", 32'(sig_n - s_sig), 64);
    chk("second_valid", 32'(valid_n - s_valid), 1);

    // async reset mid-frame
    tx_data = 16'hFFFF; send = 1'b1; tick(1); send = 1'b0; tick(20);
    chk("pre_rst_sig", 32'(tx_sig), 1);
    chk("pre_rst_bit", 32'(tx_bit), 1);
    #2 clr_n = 1'b0;
    #1;
    chk("mid_rst_sig", 32'(tx_sig), 0);
    chk("mid_rst_bit", 32'(tx_bit), 0);
    chk("mid_rst_busy", 32'(tx_busy), 0);
    chk("mid_rst_rx_data", 32'(rx_data), 0);
    tick(3);
    clr_n = 1'b1;
    snap();
    tick(100);
    chk("post_rst_sig", 32'(sig_n - s_sig), 0);
    chk("post_rst_busy", 32'(busy_n - s_busy), 0);
    chk("post_rst_valid", 32'(valid_n - s_valid), 0);
    chk("post_rst_err", 32'(err_n - s_err), 0);

    for (int i = 0; i < 4; i++) begin
      snap();
      tx_data = tbl[i].tx; send = 1'b1; exp_q.push_back(tbl[i].exp);
      tick(1); send = 1'b0; tick(85);
      chk("tbl_sig_cycles", 32'(sig_n - s_sig), 32'(tbl[i].sig));
      chk("tbl_busy_cycles", 32'(busy_n - s_busy), 32'(tbl[i].busy));
      chk("tbl_valid_cnt", 32'(valid_n - s_valid), 1);
      chk("tbl_err_cnt", 32'(err_n - s_err), 0);
      chk("tbl_rx_data", 32'(rx_data), 32'(tbl[i].exp));
    end

    // truncated frame aborts, next frame received
    loop = 1'b0;
    tick(5);
    snap();
    drive_frame(16'hFFFF, 9, 0);
    tick(20);
    chk("abort_err", 32'(err_n - s_err), 1);
    chk("abort_valid", 32'(valid_n - s_valid), 0);
    chk("abort_rx_data", 32'(rx_data), 32'hA5C3);
    snap();
    exp_q.push_back(16'h1234);
    drive_frame(16'h1234, 16, 0);
    tick(20);
    chk("after_abort_valid", 32'(valid_n - s_valid), 1);
    chk("after_abort_err", 32'(err_n - s_err), 0);
    chk("after_abort_rx", 32'(rx_data), 32'h1234);

    // sig held high long after the frame does not re-arm
    snap();
    exp_q.push_back(16'h00FF);
    drive_frame(16'h00FF, 16, 80);
    tick(20);
    chk("long_sig_valid", 32'(valid_n - s_valid), 1);
    chk("long_sig_err", 32'(err_n - s_err), 0);
    snap();
    exp_q.push_back(16'h5A5A);
    drive_frame(16'h5A5A, 16, 0);
    tick(20);
    chk("after_long_valid", 32'(valid_n - s_valid), 1);
    chk("after_long_rx", 32'(rx_data), 32'h5A5A);

    // default parameters, transmit and receive at once
    w_tx2 = 16'h8001; w_rx2 = 16'h7FFE;
    tx_data2 = w_tx2; send2 = 1'b1; drv2_sig = 1'b1;
    for (int i = 0; i < 16; i++) begin
      drv2_bit = w_rx2[i];
      tick(50);
      chk("def_tx_bit", 32'(tx_bit2), 32'(w_tx2[i]));
      tick(50);
    end
    drv2_sig = 1'b0; drv2_bit = 1'b0; send2 = 1'b0;
    tick(200);
    chk("def_sig_cycles", 32'(sig2_n), 1600);
    chk("def_busy_cycles", 32'(busy2_n), 1700);
    chk("def_valid_cnt", 32'(valid2_n), 1);
    chk("def_err_cnt", 32'(err2_n), 0);
    chk("def_rx_data", 32'(rx_data2), 32'h7FFE);

    chk("valid_err_overlap", 32'(both_n), 0);
    chk("exp_q_drained", 32'(exp_q.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
